// File: rtl/fifo_cmd_parser.sv
// Host command parser: pops opcode/argument bytes from the byte FIFO and drives cursor, attribute and cell writes.
// PUT strobes vram_wr 4 cycles after the opcode pop; a write lands on an edge where vram_wr=0 and vram_ready=1.
module fifo_cmd_parser #(
   parameter int COLS = 80,
   parameter int ROWS = 30
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        not_empty,
   output logic        rd,
   input  logic [7:0]  rd_data,
   input  logic        vram_ready,
   output logic        vram_wr,
   output logic [11:0] vram_addr,
   output logic [15:0] vram_data,
   output logic        busy,
   output logic        bad_cmd
);

   typedef enum logic [2:0] {IDLE, OP_WAIT, ARG_REQ, ARG_WAIT, EXEC, WRITE, FILL} state_t;

   localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);

   state_t      state, state_nxt;
   logic [7:0]  op, op_nxt, arg, arg_nxt, attr, attr_nxt;
   logic [4:0]  row, row_nxt;
   logic [6:0]  col, col_nxt;
   logic        rd_nxt, wr_nxt, busy_nxt, bad_nxt;
   logic [11:0] addr_nxt, cur_addr;
   logic [15:0] data_nxt;
   logic        accept;

   // row*80 + col built from shifts
   assign cur_addr = {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col};
   assign accept   = !vram_wr && vram_ready;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= IDLE;
         rd        <= 1'b1;
         vram_wr   <= 1'b1;
         vram_addr <= '0;
         vram_data <= '0;
         busy      <= 1'b0;
         bad_cmd   <= 1'b0;
         row       <= '0;
         col       <= '0;
         attr      <= 8'h07;
         op        <= '0;
         arg       <= '0;
      end else begin
         state     <= state_nxt;
         rd        <= rd_nxt;
         vram_wr   <= wr_nxt;
         vram_addr <= addr_nxt;
         vram_data <= data_nxt;
         busy      <= busy_nxt;
         bad_cmd   <= bad_nxt;
         row       <= row_nxt;
         col       <= col_nxt;
         attr      <= attr_nxt;
         op        <= op_nxt;
         arg       <= arg_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rd_nxt    = 1'b1;
      wr_nxt    = vram_wr;
      addr_nxt  = vram_addr;
      data_nxt  = vram_data;
      bad_nxt   = bad_cmd;
      row_nxt   = row;
      col_nxt   = col;
      attr_nxt  = attr;
      op_nxt    = op;
      arg_nxt   = arg;
      case (state)
         // A low rd means the pop was issued last cycle; move on rather than pop twice.
         IDLE: begin
            if (!rd)            state_nxt = OP_WAIT;
            else if (not_empty) rd_nxt = 1'b0;
         end
         OP_WAIT: begin
            op_nxt = rd_data;
            if (rd_data >= 8'h01 && rd_data <= 8'h05) begin
               state_nxt = ARG_REQ;
               if (not_empty) rd_nxt = 1'b0;
            end else begin
               state_nxt = IDLE;
               bad_nxt   = 1'b1;
            end
         end
         ARG_REQ: begin
            if (!rd)            state_nxt = ARG_WAIT;
            else if (not_empty) rd_nxt = 1'b0;
         end
         ARG_WAIT: begin
            arg_nxt = rd_data;
            case (op)
               8'h04: begin
                  state_nxt = WRITE;
                  addr_nxt  = cur_addr;
                  data_nxt  = {attr, rd_data};
                  wr_nxt    = !vram_ready;
               end
               8'h05: begin
                  state_nxt = FILL;
                  addr_nxt  = '0;
                  data_nxt  = {attr, rd_data};
                  wr_nxt    = !vram_ready;
               end
               default: state_nxt = EXEC;
            endcase
         end
         EXEC: begin
            state_nxt = IDLE;
            case (op)
               8'h01: if (arg < 8'(ROWS)) row_nxt = arg[4:0]; else bad_nxt = 1'b1;
               8'h02: if (arg < 8'(COLS)) col_nxt = arg[6:0]; else bad_nxt = 1'b1;
               8'h03: attr_nxt = arg;
               default: ;
            endcase
         end
         WRITE: begin
            if (accept) begin
               state_nxt = IDLE;
               wr_nxt    = 1'b1;
               if (col == 7'(COLS - 1)) begin
                  col_nxt = '0;
                  row_nxt = (row == 5'(ROWS - 1)) ? 5'd0 : row + 5'd1;
               end else begin
                  col_nxt = col + 7'd1;
               end
            end else begin
               wr_nxt = !vram_ready;
            end
         end
         FILL: begin
            if (accept && vram_addr == LAST_CELL) begin
               state_nxt = IDLE;
               wr_nxt    = 1'b1;
               row_nxt   = '0;
               col_nxt   = '0;
            end else begin
               if (accept) addr_nxt = vram_addr + 12'd1;
               wr_nxt = !vram_ready;
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_fifo_cmd_parser.sv
// Directed bench for fifo_cmd_parser: byte-FIFO model, write log, per-scenario checks.
module tb_fifo_cmd_parser;
   logic        clk = 1'b0;
   logic        nrst, not_empty, rd, vram_ready, vram_wr, busy, bad_cmd;
   logic [7:0]  rd_data = 8'h00;
   logic [11:0] vram_addr;
   logic [15:0] vram_data;

   int nvec = 0;
   int nerr = 0;

   logic [7:0]  mem [0:1023];
   int          wp = 0;
   int          rp = 0;
   logic [11:0] wa [$];
   logic [15:0] wd [$];
   int          rd_bad = 0;

   fifo_cmd_parser dut (
      .clk(clk), .nrst(nrst), .not_empty(not_empty), .rd(rd), .rd_data(rd_data),
      .vram_ready(vram_ready), .vram_wr(vram_wr), .vram_addr(vram_addr),
      .vram_data(vram_data), .busy(busy), .bad_cmd(bad_cmd)
   );

   always #5 clk = ~clk;

   assign not_empty = (wp != rp);

   always @(posedge clk) begin
      if (!nrst) rp <= wp;
      else if (!rd && wp != rp) begin
         rd_data <= mem[rp[9:0]];
         rp      <= rp + 1;
      end
   end

   always @(negedge clk) begin
      if (nrst) begin
         if (!rd && !not_empty) rd_bad <= rd_bad + 1;
         if (!vram_wr && vram_ready) begin
            wa.push_back(vram_addr);
            wd.push_back(vram_data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      mem[wp[9:0]] = b;
      wp = wp + 1;
   endtask

   task automatic wait_idle(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (!busy && rd && !not_empty) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      vram_ready = 1'b1;
      repeat (3) @(negedge clk);
      nvec++; if (rd !== 1'b1)         begin nerr++; $display("FAIL reset_rd: got %b want 1", rd); end
      nvec++; if (vram_wr !== 1'b1)    begin nerr++; $display("FAIL reset_wr: got %b want 1", vram_wr); end
      nvec++; if (vram_addr !== 12'd0) begin nerr++; $display("FAIL reset_addr: got %0d want 0", vram_addr); end
      nvec++; if (vram_data !== 16'h0) begin nerr++; $display("FAIL reset_data: got %h want 0000", vram_data); end
      nvec++; if (busy !== 1'b0)       begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
      nvec++; if (bad_cmd !== 1'b0)    begin nerr++; $display("FAIL reset_bad: got %b want 0", bad_cmd); end
      tick();
      nrst = 1'b1;
      push(8'h05); push(8'h41);
      repeat (60) tick();
      nvec++; if (busy !== 1'b1 || vram_wr !== 1'b0) begin
         nerr++; $display("FAIL fill_running: busy=%b wr=%b want busy=1 wr=0", busy, vram_wr);
      end
      nrst = 1'b0;
      #1;
      nvec++; if (rd !== 1'b1 || vram_wr !== 1'b1 || busy !== 1'b0 || bad_cmd !== 1'b0) begin
         nerr++; $display("FAIL async_reset_ctl: rd=%b wr=%b busy=%b bad=%b want 1 1 0 0", rd, vram_wr, busy, bad_cmd);
      end
      nvec++; if (vram_addr !== 12'd0 || vram_data !== 16'h0) begin
         nerr++; $display("FAIL async_reset_bus: addr=%0d data=%h want 0 0000", vram_addr, vram_data);
      end
      repeat (3) tick();
      nrst = 1'b1;
      tick();
   endtask

   task automatic test_put_timing();
      logic [6:0] exp_rd, exp_wr, exp_busy;
      int  base;
      bit  ok;
      exp_rd   = 7'b1110101;
      exp_wr   = 7'b1011111;
      exp_busy = 7'b0111100;
      base = wa.size();
      push(8'h04); push(8'h41);
      // index i observes cycle i-1 relative to the opcode pop
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         nvec++; if (rd !== exp_rd[i])     begin nerr++; $display("FAIL put_rd[%0d]: got %b want %b", i - 1, rd, exp_rd[i]); end
         nvec++; if (vram_wr !== exp_wr[i]) begin nerr++; $display("FAIL put_wr[%0d]: got %b want %b", i - 1, vram_wr, exp_wr[i]); end
         nvec++; if (busy !== exp_busy[i]) begin nerr++; $display("FAIL put_busy[%0d]: got %b want %b", i - 1, busy, exp_busy[i]); end
      end
      wait_idle(50, ok);
      nvec++; if (!ok) begin nerr++; $display("FAIL put_idle: timeout got busy=%b want 0", busy); end
      nvec++; if (wa.size() - base !== 1) begin nerr++; $display("FAIL put_count: got %0d want 1", wa.size() - base); end
      else begin
         nvec++; if (wa[base] !== 12'd0 || wd[base] !== 16'h0741) begin
            nerr++; $display("FAIL put_cell: got %0d/%h want 0/0741", wa[base], wd[base]);
         end
      end
   endtask

   task automatic test_preload();
      int base;
      bit ok;
      base = wa.size();
      push(8'h01); push(8'h05); push(8'h02); push(8'h0A); push(8'h04); push(8'h41);
      push(8'h04); push(8'h42);
      wait_idle(200, ok);
      nvec++; if (!ok) begin nerr++; $display("FAIL preload_idle: timeout got busy=%b want 0", busy); end
      nvec++; if (wa.size() - base !== 2) begin nerr++; $display("FAIL preload_count: got %0d want 2", wa.size() - base); end
      else begin
         nvec++; if (wa[base] !== 12'd410 || wd[base] !== 16'h0741) begin
            nerr++; $display("FAIL preload_cell: got %0d/%h want 410/0741", wa[base], wd[base]);
         end
         nvec++; if (wa[base+1] !== 12'd411 || wd[base+1] !== 16'h0742) begin
            nerr++; $display("FAIL preload_advance: got %0d/%h want 411/0742", wa[base+1], wd[base+1]);
         end
      end
   endtask

   task automatic test_wrap();
      int base;
      bit ok;
      base = wa.size();
      push(8'h01); push(8'h1D); push(8'h02); push(8'h4F);
      push(8'h04); push(8'h58); push(8'h04); push(8'h59); push(8'h04); push(8'h5A);
      wait_idle(300, ok);
      nvec++; if (!ok) begin nerr++; $display("FAIL wrap_idle: timeout got busy=%b want 0", busy); end
      nvec++; if (wa.size() - base !== 3) begin nerr++; $display("FAIL wrap_count: got %0d want 3", wa.size() - base); end
      else begin
         nvec++; if (wa[base] !== 12'd2399 || wd[base] !== 16'h0758) begin
            nerr++; $display("FAIL wrap_last: got %0d/%h want 2399/0758", wa[base], wd[base]);
         end
         nvec++; if (wa[base+1] !== 12'd0 || wd[base+1] !== 16'h0759) begin
            nerr++; $display("FAIL wrap_first: got %0d/%h want 0/0759", wa[base+1], wd[base+1]);
         end
         nvec++; if (wa[base+2] !== 12'd1) begin
            nerr++; $display("FAIL wrap_next: got %0d want 1", wa[base+2]);
         end
      end
   endtask

   task automatic test_bad_input();
      int base;
      bit ok;
      nvec++; if (bad_cmd !== 1'b0) begin nerr++; $display("FAIL bad_pre: got %b want 0", bad_cmd); end
      base = wa.size();
      push(8'h7E);
      wait_idle(50, ok);
      nvec++; if (!ok || bad_cmd !== 1'b1) begin
         nerr++; $display("FAIL bad_opcode: idle=%b bad=%b want 1 1", ok, bad_cmd);
      end
      nvec++; if (rp !== wp) begin nerr++; $display("FAIL bad_pops: left %0d bytes want 0", wp - rp); end
      push(8'h01); push(8'h1E); push(8'h04); push(8'h43);
      wait_idle(200, ok);
      nvec++; if (!ok || bad_cmd !== 1'b1) begin
         nerr++; $display("FAIL bad_sticky: idle=%b bad=%b want 1 1", ok, bad_cmd);
      end
      nvec++; if (wa.size() - base !== 1) begin nerr++; $display("FAIL bad_count: got %0d want 1", wa.size() - base); end
      else begin
         nvec++; if (wa[base] !== 12'd2 || wd[base] !== 16'h0743) begin
            nerr++; $display("FAIL bad_row_kept: got %0d/%h want 2/0743", wa[base], wd[base]);
         end
      end
   endtask

   task automatic test_backpressure();
      int base;
      bit ok;
      base = wa.size();
      vram_ready = 1'b0;
      push(8'h04); push(8'h44);
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         nvec++; if (vram_wr !== 1'b1) begin nerr++; $display("FAIL bp_wr[%0d]: got %b want 1", i, vram_wr); end
         if (i >= 6) begin
            nvec++; if (vram_addr !== 12'd3 || vram_data !== 16'h0744) begin
               nerr++; $display("FAIL bp_hold[%0d]: got %0d/%h want 3/0744", i, vram_addr, vram_data);
            end
         end
      end
      tick();
      vram_ready = 1'b1;
      wait_idle(20, ok);
      nvec++; if (!ok) begin nerr++; $display("FAIL bp_idle: timeout got busy=%b want 0", busy); end
      nvec++; if (wa.size() - base !== 1) begin nerr++; $display("FAIL bp_count: got %0d want 1", wa.size() - base); end
      else begin
         nvec++; if (wa[base] !== 12'd3 || wd[base] !== 16'h0744) begin
            nerr++; $display("FAIL bp_cell: got %0d/%h want 3/0744", wa[base], wd[base]);
         end
      end
   endtask

   task automatic test_fill();
      int base, addr_err, data_err;
      bit ok;
      base = wa.size();
      ok = 1'b0;
      push(8'h03); push(8'h1F); push(8'h05); push(8'h20);
      for (int i = 0; i < 40000; i++) begin
         tick();
         vram_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (!busy && rd && !not_empty) begin
            ok = 1'b1;
            break;
         end
      end
      vram_ready = 1'b1;
      nvec++; if (!ok) begin nerr++; $display("FAIL fill_idle: timeout got busy=%b want 0", busy); end
      nvec++; if (wa.size() - base !== 2400) begin nerr++; $display("FAIL fill_count: got %0d want 2400", wa.size() - base); end
      addr_err = 0;
      data_err = 0;
      for (int i = 0; i < 2400 && base + i < wa.size(); i++) begin
         if (wa[base+i] !== 12'(i)) addr_err++;
         if (wd[base+i] !== 16'h1F20) data_err++;
      end
      nvec++; if (addr_err !== 0) begin nerr++; $display("FAIL fill_order: got %0d bad addresses want 0", addr_err); end
      nvec++; if (data_err !== 0) begin nerr++; $display("FAIL fill_data: got %0d bad words want 0", data_err); end
      tick();
      base = wa.size();
      push(8'h04); push(8'h21);
      wait_idle(50, ok);
      nvec++; if (wa.size() - base !== 1) begin nerr++; $display("FAIL fill_cursor_count: got %0d want 1", wa.size() - base); end
      else begin
         nvec++; if (wa[base] !== 12'd0 || wd[base] !== 16'h1F21) begin
            nerr++; $display("FAIL fill_cursor: got %0d/%h want 0/1F21", wa[base], wd[base]);
         end
      end
      nvec++; if (rd_bad !== 0) begin nerr++; $display("FAIL rd_when_empty: got %0d cycles want 0", rd_bad); end
   endtask

   initial begin
      test_reset();
      test_put_timing();
      test_preload();
      test_wrap();
      test_bad_input();
      test_backpressure();
      test_fill();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/fifo_cmd_parser.md
# fifo_cmd_parser

Command parser directly downstream of the 512x8 host byte FIFO. Pops bytes from the FIFO through its active-low read strobe and decodes a small opcode/argument protocol. Maintains a text cursor and an attribute register. Issues 16-bit cell writes (attribute:character) into the 80x30 character RAM.

## Interface
Parameters:
- COLS, 80, characters per row
- ROWS, 30, rows per screen

Ports:
- clk  input  1  system clock
- nrst  input  1  reset; asynchronous, active-low (0 = reset asserted)
- not_empty  input  1  FIFO has data (from FIFO)
- rd  output  1  FIFO read strobe, active-low, one cycle
- rd_data  input  8  FIFO read data, valid the cycle after the edge that sampled rd=0
- vram_ready  input  1  character RAM accepts a write this cycle
- vram_wr  output  1  cell write strobe, active-low
- vram_addr  output  12  cell index, row*COLS+col, 0..2399
- vram_data  output  16  {attr[7:0], char[7:0]}
- busy  output  1  1 whenever state != IDLE
- bad_cmd  output  1  sticky: unknown opcode or out-of-range argument seen; cleared only by reset

## Operation
- Protocol: opcode byte followed by exactly one argument byte.
  - 0x01 SET_ROW r: row=r if r<ROWS, else bad_cmd=1 and row unchanged.
  - 0x02 SET_COL c: col=c if c<COLS, else bad_cmd=1.
  - 0x03 SET_ATTR a: attr=a.
  - 0x04 PUT ch: write {attr,ch} at (row,col), then advance the cursor.
  - 0x05 FILL ch: write {attr,ch} to cells 0..2399 in ascending order, then row=col=0.
  - Any other opcode: bad_cmd=1; argument not consumed; byte dropped.
- Cursor advance: col+1. At col=COLS-1, col=0 and row+1. At row=ROWS-1 with col=COLS-1, the cursor wraps to (0,0).
- Address arithmetic: row*64 + row*16 + col, 12-bit, no multiplier.
- States:
  - IDLE: if not_empty, drive rd=0 and go to OP_WAIT.
  - OP_WAIT: latch rd_data as opcode. Go to ARG_REQ if the opcode is valid, else IDLE.
  - ARG_REQ: wait for not_empty; drive rd=0 and go to ARG_WAIT.
  - ARG_WAIT: latch the argument. Go to EXEC for 0x01–0x03, WRITE for 0x04, FILL for 0x05.
  - EXEC: update the register; go to IDLE.
  - WRITE: present addr/data; vram_wr=0 while vram_ready=1; on accept, advance the cursor and go to IDLE.
  - FILL: same strobe rule. The address counter increments on each accepted write. After address 2399 is accepted, reset the cursor and go to IDLE.
- rd is driven low only in IDLE/ARG_REQ and only while not_empty=1. Never two consecutive cycles; at most one pop per two cycles.
- Reset values: rd=1, vram_wr=1, vram_addr=0, vram_data=0, busy=0, bad_cmd=0, row=0, col=0, attr=0x07, state IDLE.
- Reset mid-command or mid-FILL: abandon immediately; partial argument discarded; outputs take reset values asynchronously.

## Timing
- rd, vram_wr, vram_addr, vram_data, busy are registered outputs; no combinational input-to-output paths.
- PUT with FIFO pre-loaded and vram_ready=1:
  - opcode pop at cycle 0
  - argument pop at cycle 2
  - vram_wr=0 at cycle 4
  - busy=0 at cycle 5
- vram_ready=0 in WRITE/FILL: vram_wr stays 1, and addr/data are held stable until ready returns.
- FILL with vram_ready=1: one cell per cycle, 2400 write cycles.
- FIFO empty in ARG_REQ: wait indefinitely; busy stays 1.

## Test plan
- Reset: hold nrst=0 mid-FILL -> all outputs at reset values within the same cycle; after release, idle with busy=0 and cursor (0,0).
- Preload 0x01,0x05,0x02,0x0A,0x04,0x41 -> exactly one vram_wr pulse with addr=410 and data=0x0741; cursor ends at (5,11).
- Cursor wrap: SET_ROW 29, SET_COL 79, PUT 'X', PUT 'Y' -> writes at addr 2399 then addr 0.
- Bad input: opcode 0x7E, then SET_ROW 30 -> bad_cmd=1; row unchanged; no vram write; next valid PUT still executes.
- Backpressure: during PUT hold vram_ready=0 for 5 cycles -> vram_wr=1 and addr/data stable; single write on the cycle vram_ready=1.
- FILL 0x20 with attr 0x1F and random vram_ready -> 2400 writes, addresses 0..2399 exactly once each, data=0x1F20; cursor (0,0); rd never low while not_empty=0.
